// File: rtl/dice_roller.sv
// Two-die roller: free-running face counters are sampled while the button is held,
// animating the display every TICK_DIV cycles, and latched as the result on release.
module dice_roller #(
    parameter int TICK_DIV = 4,
    parameter int MIN_HOLD = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       roll,
    output logic [3:0] dice1,
    output logic [3:0] dice2,
    output logic [3:0] sum,
    output logic       display_en,
    output logic       valid,
    output logic       busy
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(MIN_HOLD + 1);

    typedef enum logic {IDLE, ROLLING} state_t;

    state_t        state, state_next;
    logic [2:0]    c1, c2;
    logic          roll_q;
    logic [TW-1:0] tick_cnt;
    logic [HW-1:0] hold_cnt;
    logic          press, tick, finish;

    assign press = roll & ~roll_q;
    assign busy  = (state == ROLLING);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        tick       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (press) state_next = ROLLING;
            ROLLING: begin
                tick = (tick_cnt == TW'(TICK_DIV - 1));
                if (!roll && hold_cnt == HW'(MIN_HOLD)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // roll_q starts high so a button held through reset is not a press
            roll_q     <= 1'b1;
            c1         <= 3'd1;
            c2         <= 3'd1;
            tick_cnt   <= '0;
            hold_cnt   <= '0;
            dice1      <= 4'd0;
            dice2      <= 4'd0;
            sum        <= 4'd0;
            display_en <= 1'b0;
            valid      <= 1'b0;
        end else begin
            roll_q <= roll;
            c1     <= (c1 == 3'd6) ? 3'd1 : c1 + 3'd1;
            if (c1 == 3'd6) c2 <= (c2 == 3'd6) ? 3'd1 : c2 + 3'd1;

            display_en <= tick | finish;
            valid      <= finish;

            if (state == IDLE) begin
                if (press) begin
                    tick_cnt <= '0;
                    hold_cnt <= '0;
                end
            end else begin
                if (hold_cnt != HW'(MIN_HOLD)) hold_cnt <= hold_cnt + 1'b1;
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                // exit and tick share one latch of the pre-advance faces
                if (tick || finish) begin
                    dice1 <= {1'b0, c1};
                    dice2 <= {1'b0, c2};
                end
                if (finish) sum <= {1'b0, c1} + {1'b0, c2};
            end
        end
    end
endmodule

// File: tb/tb_dice_roller.sv
// Self-checking bench: directed scenarios plus random button/reset activity, all
// outputs compared every cycle against an arithmetic model of the roller.
module tb_dice_roller;
    localparam int TD = 4;
    localparam int MH = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       roll  = 1'b0;
    logic [3:0] dice1, dice2, sum;
    logic       display_en, valid, busy;

    int total = 0;
    int bad   = 0;

    // model: n = counter advances since reset (mod 36), j = ROLLING edges since entry
    int       n = 0;
    int       j = 0;
    bit       m_rolling = 0;
    bit       m_rq = 1;
    int       m_d1 = 0, m_d2 = 0, m_sum = 0;
    bit       m_de = 0, m_v = 0;
    int       valid_seen = 0;

    dice_roller #(.TICK_DIV(TD), .MIN_HOLD(MH)) dut (
        .clock(clock), .reset(reset), .roll(roll),
        .dice1(dice1), .dice2(dice2), .sum(sum),
        .display_en(display_en), .valid(valid), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic void model_edge(input bit r, input bit rst);
        int f1, f2;
        bit ex, tk;
        if (rst) begin
            n = 0; m_rolling = 0; m_rq = 1;
            m_d1 = 0; m_d2 = 0; m_sum = 0; m_de = 0; m_v = 0;
            return;
        end
        f1 = n % 6 + 1;
        f2 = (n / 6) % 6 + 1;
        m_de = 0; m_v = 0;
        if (!m_rolling) begin
            if (r && !m_rq) begin
                m_rolling = 1;
                j = 0;
            end
        end else begin
            ex = !r && (j >= MH);
            tk = (j % TD) == TD - 1;
            if (tk || ex) begin
                m_d1 = f1; m_d2 = f2; m_de = 1;
            end
            if (ex) begin
                m_sum = f1 + f2; m_v = 1; m_rolling = 0;
            end
            j++;
        end
        m_rq = r;
        n = (n + 1) % 36;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("dice1", int'(dice1), m_d1);
        chk("dice2", int'(dice2), m_d2);
        chk("sum", int'(sum), m_sum);
        chk("display_en", int'(display_en), int'(m_de));
        chk("valid", int'(valid), int'(m_v));
        chk("busy", int'(busy), int'(m_rolling));
        if (valid === 1'b1) valid_seen++;
    endtask

    task automatic step(input bit r, input bit rst);
        roll  = r;
        reset = rst;
        @(posedge clock);
        model_edge(r, rst);
        #1;
        check_all();
    endtask

    initial begin
        int hold_left;
        bit r;

        // reset state, then idle for 7 edges: no activity on outputs
        step(0, 1);
        step(0, 1);
        for (int i = 0; i < 7; i++) step(0, 0);
        chk("idle_de", int'(display_en), 0);

        // exit edge after exactly 19 advances since reset gives faces 2 and 4
        step(0, 1);
        step(0, 0);                            // edge 1
        for (int i = 2; i <= 19; i++) step(1, 0); // press at edge 2, hold
        step(0, 0);                            // edge 20, pre-advance n = 19
        chk("r29_dice1", int'(dice1), 2);
        chk("r29_dice2", int'(dice2), 4);
        chk("r29_sum", int'(sum), 6);
        chk("r29_valid", int'(valid), 1);
        chk("r29_de", int'(display_en), 1);
        chk("r29_busy", int'(busy), 0);

        // short press: rolling continues until hold count is reached, one valid
        valid_seen = 0;
        step(0, 0);
        step(1, 0); step(1, 0); step(0, 0);
        for (int i = 0; i < 12; i++) step(0, 0);
        chk("short_press_valids", valid_seen, 1);
        chk("short_press_idle", int'(busy), 0);

        // long hold with a re-press in the middle (ignored)
        step(1, 0);
        for (int i = 0; i < 10; i++) step(1, 0);
        step(0, 0); step(1, 0);
        for (int i = 0; i < 10; i++) step(1, 0);
        for (int i = 0; i < 4; i++) step(0, 0);

        // button held through reset release: no roll until release and press
        step(1, 1);
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("held_reset_busy", int'(busy), 0);
        step(0, 0);
        step(1, 0);
        chk("repress_busy", int'(busy), 1);

        // reset mid-roll aborts without valid; next press rolls normally
        step(1, 0); step(1, 0);
        step(1, 1);
        chk("abort_valid", int'(valid), 0);
        chk("abort_busy", int'(busy), 0);
        step(0, 0); step(1, 0);
        for (int i = 0; i < 12; i++) step(0, 0);

        // random button and occasional reset
        r = 0;
        hold_left = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold_left == 0) begin
                r = ~r;
                hold_left = $urandom_range(r ? 25 : 6, 1);
            end
            hold_left--;
            step(r, $urandom_range(79, 0) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
